// File: rtl/grom_io_uart_tx.sv
// grom_io_uart_tx: IO-mapped 8N1 UART transmitter for the grom_cpu IO bus.
// CPU writes are queued in a small FIFO; a status port reports fill level, overflow and idle.
module grom_io_uart_tx #(
  parameter logic [11:0] BASE_ADDR  = 12'h000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        we,
  input  logic        ioreq,
  output logic        tx,
  output logic        busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(CLK_DIV);

  localparam logic [11:0]   CTRL_ADDR = BASE_ADDR + 12'd1;
  localparam logic [AW:0]   DEPTH     = AW1'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic       w_wr_data;
  logic       w_wr_ctrl;
  logic       w_rd_stat;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_cyc_end;
  logic [4:0] w_cnt_ext;
  logic [3:0] w_cnt4;

  assign w_wr_data = ioreq & we & (addr == BASE_ADDR);
  assign w_wr_ctrl = ioreq & we & (addr == CTRL_ADDR);
  assign w_rd_stat = ioreq & ~we & (addr == CTRL_ADDR);
  assign w_full    = (r_count == DEPTH);
  assign w_empty   = (r_count == '0);
  // Full is judged on the pre-pop count, so a push into a full FIFO drops even if a pop happens too.
  assign w_push    = w_wr_data & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_cyc_end = (r_cyc == CYC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + AW1'(1);
        2'b01:   r_count <= r_count - AW1'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_data && w_full)
        r_ovf <= 1'b1;
      else if (w_wr_ctrl && data_in[0])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (w_pop)
      r_shift <= r_mem[r_rd_ptr];
    else if ((r_state == S_DATA) && w_cyc_end)
      r_shift <= {1'b0, r_shift[7:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cyc <= '0;
          if (!w_empty) r_state <= S_START;
        end
        S_START: begin
          if (w_cyc_end) begin
            r_state <= S_DATA;
            r_cyc   <= '0;
            r_bit   <= '0;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cyc_end) begin
            r_cyc <= '0;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_STOP: begin
          if (w_cyc_end) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // tx decoded from state so an async reset forces the line high immediately.
  always_comb begin
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy      = ~w_empty | (r_state != S_IDLE);
  assign w_cnt_ext = 5'(r_count);
  assign w_cnt4    = (w_cnt_ext > 5'd15) ? 4'hF : w_cnt_ext[3:0];
  assign data_out  = w_rd_stat ? {w_cnt4, 1'b0, r_ovf, ~busy, ~w_full} : 8'h00;

endmodule
